// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Sequencing controller for the PC address mux. Accepts decoded jump/branch
// indications from decode, waits for the branch comparator when a conditional
// branch is seen, drives the mux branch code for exactly one cycle per taken
// redirect and then holds a flush window so wrong-path fetches are discarded.
//
// Parameters
//   FLUSH_CYCLES  bubble cycles flushed per redirect, including the redirect
//                 cycle itself. Legal range 1..7.
//   CNT_RESET     value loaded into redirectcnt by reset (normally 0).
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   instvalid    in   decode-stage instruction valid
//   isjump       in   decoded instruction is an unconditional jump
//   isbranch     in   decoded instruction is a conditional branch
//   branchne     in   branch sense: 0 = beq, 1 = bne
//   cmpvalid     in   comparator result valid
//   cmpequal     in   comparator result: operands equal
//   branchcode   out  PC mux select: 00 NOLOAD, 01 SELJUMP, 10 SELBRANCH
//   flush        out  squash IF/ID contents this cycle
//   stall        out  hold fetch/decode this cycle
//   busy         out  controller not idle
//   redirectcnt  out  saturating count of taken redirects
//
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [15:0] CNT_RESET    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instvalid,
    input  logic        isjump,
    input  logic        isbranch,
    input  logic        branchne,
    input  logic        cmpvalid,
    input  logic        cmpequal,
    output logic [1:0]  branchcode,
    output logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [15:0] redirectcnt
);

    localparam logic [1:0] CODE_NOLOAD    = 2'b00;
    localparam logic [1:0] CODE_SELJUMP   = 2'b01;
    localparam logic [1:0] CODE_SELBRANCH = 2'b10;

    // Value the flush counter starts at on entering FLUSH; the REDIRECT cycle
    // already accounts for one of the FLUSH_CYCLES bubbles.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAITCMP  = 2'd1,
        S_REDIRECT = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic        kind_q, kind_d;      // 0 = jump, 1 = branch
    logic        bne_q, bne_d;        // branch sense held through WAITCMP
    logic [15:0] rcnt_q, rcnt_d;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= 3'd0;
            kind_q  <= 1'b0;
            bne_q   <= 1'b0;
            rcnt_q  <= CNT_RESET;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            kind_q  <= kind_d;
            bne_q   <= bne_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        kind_d  = kind_q;
        bne_d   = bne_q;
        rcnt_d  = rcnt_q;

        case (state_q)
            S_IDLE: begin
                // A jump wins when both decode flags are raised together.
                if (instvalid && isjump) begin
                    kind_d  = 1'b0;
                    state_d = S_REDIRECT;
                end else if (instvalid && isbranch) begin
                    bne_d   = branchne;
                    state_d = S_WAITCMP;
                end
            end

            S_WAITCMP: begin
                if (cmpvalid) begin
                    if (cmpequal ^ bne_q) begin
                        kind_d  = 1'b1;
                        state_d = S_REDIRECT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_REDIRECT: begin
                if (rcnt_q != 16'hFFFF) begin
                    rcnt_d = rcnt_q + 16'd1;
                end
                if (FLUSH_CYCLES <= 1) begin
                    state_d = S_IDLE;
                end else begin
                    fcnt_d  = FLUSH_LOAD;
                    state_d = S_FLUSH;
                end
            end

            S_FLUSH: begin
                fcnt_d = fcnt_q - 3'd1;
                // Counter value 1 marks the last flush bubble.
                if (fcnt_q <= 3'd1) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (state only, no input-to-output path)
    // -------------------------------------------------------------------------
    always_comb begin
        branchcode = CODE_NOLOAD;
        if (state_q == S_REDIRECT) begin
            branchcode = kind_q ? CODE_SELBRANCH : CODE_SELJUMP;
        end
        flush       = (state_q == S_REDIRECT) || (state_q == S_FLUSH);
        stall       = (state_q == S_WAITCMP);
        busy        = (state_q != S_IDLE);
        redirectcnt = rcnt_q;
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Two instances share one stimulus stream: dut0 with FLUSH_CYCLES = 2 and a
// zero count reset, dut1 with FLUSH_CYCLES = 1 and the count reset near
// saturation. A directed vector table checks dut0 against hand-derived values;
// an event-level model (pending flush window length + "waiting for compare"
// flag) checks both instances every cycle, including a random phase.
// -----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

    logic clk;
    logic rst, iv, ij, ib, bne, cv, ceq;

    logic [1:0]  code0, code1;
    logic        fl0, fl1, st0, st1, bz0, bz1;
    logic [15:0] cnt0, cnt1;

    pc_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_RESET(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .instvalid(iv), .isjump(ij), .isbranch(ib),
        .branchne(bne), .cmpvalid(cv), .cmpequal(ceq),
        .branchcode(code0), .flush(fl0), .stall(st0), .busy(bz0),
        .redirectcnt(cnt0)
    );

    pc_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_RESET(16'hFFF0)) dut1 (
        .clk(clk), .rst(rst), .instvalid(iv), .isjump(ij), .isbranch(ib),
        .branchne(bne), .cmpvalid(cv), .cmpequal(ceq),
        .branchcode(code1), .flush(fl1), .stall(st1), .busy(bz1),
        .redirectcnt(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // ---------------- reference model ----------------
    int       fc    [2] = '{2, 1};
    int       pre   [2] = '{0, 'hFFF0};
    int       fl_left[2];   // flush-window cycles still to be shown
    int       fl_code[2];   // code shown in the current window cycle
    bit       waiting[2];   // branch accepted, compare result pending
    bit       mbne   [2];
    int       mcnt   [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            fl_left[k] = 0;
            fl_code[k] = 0;
            waiting[k] = 0;
            mbne[k]    = 0;
            mcnt[k]    = pre[k];
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                fl_left[k] = 0;
                fl_code[k] = 0;
                waiting[k] = 0;
                mbne[k]    = 0;
                mcnt[k]    = pre[k];
            end else if (fl_left[k] > 0) begin
                if (fl_code[k] != 0 && mcnt[k] < 65535) mcnt[k]++;
                fl_code[k] = 0;
                fl_left[k]--;
            end else if (waiting[k]) begin
                if (cv) begin
                    waiting[k] = 0;
                    if (ceq != mbne[k]) begin
                        fl_left[k] = fc[k];
                        fl_code[k] = 2;
                    end
                end
            end else if (iv && ij) begin
                fl_left[k] = fc[k];
                fl_code[k] = 1;
            end else if (iv && ib) begin
                waiting[k] = 1;
                mbne[k]    = bne;
            end
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h",
                     nm, k, cyc, got, exp);
        end
    endtask

    task automatic check_model();
        logic [1:0]  g_code;
        logic        g_fl, g_st, g_bz;
        logic [15:0] g_cnt;
        int          e_code;
        bit          e_fl, e_st;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                g_code = code0; g_fl = fl0; g_st = st0; g_bz = bz0; g_cnt = cnt0;
            end else begin
                g_code = code1; g_fl = fl1; g_st = st1; g_bz = bz1; g_cnt = cnt1;
            end
            e_fl   = (fl_left[k] > 0);
            e_code = e_fl ? fl_code[k] : 0;
            e_st   = !e_fl && waiting[k];
            chk("mdl_code",  k, 32'(g_code), 32'(e_code));
            chk("mdl_flush", k, 32'(g_fl),   32'(e_fl));
            chk("mdl_stall", k, 32'(g_st),   32'(e_st));
            chk("mdl_busy",  k, 32'(g_bz),   32'(e_fl || e_st));
            chk("mdl_cnt",   k, 32'(g_cnt),  32'(mcnt[k]));
        end
    endtask

    // Apply inputs, clock one edge, then compare away from the edge.
    task automatic step(input bit r, input bit a, input bit j, input bit b,
                        input bit n, input bit v, input bit e);
        rst = r; iv = a; ij = j; ib = b; bne = n; cv = v; ceq = e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_model();
    endtask

    // ---------------- directed vectors for dut0 ----------------
    typedef struct {
        bit r, a, j, b, n, v, e;
        int code;
        bit fl, st, bz;
        int cnt;
    } vec_t;

    localparam int NV = 37;
    vec_t tbl[NV];

    initial begin
        rst = 1'b1; iv = 0; ij = 0; ib = 0; bne = 0; cv = 0; ceq = 0;
        model_reset();

        //            r a j b n v e  code fl st bz cnt
        tbl[0]  = '{1,0,0,0,0,0,0, 0, 0,0,0, 0};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{0,0,0,0,0,0,0, 0, 0,0,0, 0};
        tbl[6]  = '{0,1,1,0,0,0,0, 1, 1,0,1, 0};   // jump accepted
        tbl[7]  = '{0,0,0,0,0,0,0, 0, 1,0,1, 1};
        tbl[8]  = '{0,0,0,0,0,0,0, 0, 0,0,0, 1};
        tbl[9]  = '{0,1,0,1,0,0,0, 0, 0,1,1, 1};   // beq accepted
        tbl[10] = '{0,0,0,0,0,0,0, 0, 0,1,1, 1};
        tbl[11] = '{0,0,0,0,0,0,0, 0, 0,1,1, 1};
        tbl[12] = '{0,0,0,0,0,1,1, 2, 1,0,1, 1};   // equal -> taken
        tbl[13] = '{0,0,0,0,0,0,0, 0, 1,0,1, 2};
        tbl[14] = '{0,0,0,0,0,0,0, 0, 0,0,0, 2};
        tbl[15] = '{0,1,0,1,1,0,0, 0, 0,1,1, 2};   // bne accepted
        tbl[16] = '{0,0,0,0,0,1,1, 0, 0,0,0, 2};   // equal -> not taken
        tbl[17] = '{0,1,1,0,0,0,0, 1, 1,0,1, 2};   // jump in first idle cycle
        tbl[18] = '{0,0,0,0,0,0,0, 0, 1,0,1, 3};
        tbl[19] = '{0,0,0,0,0,0,0, 0, 0,0,0, 3};
        tbl[20] = '{0,1,1,1,0,0,0, 1, 1,0,1, 3};   // jump+branch: jump wins
        tbl[21] = '{0,1,1,0,0,0,0, 0, 1,0,1, 4};   // ignored in REDIRECT
        tbl[22] = '{0,1,1,0,0,0,0, 0, 0,0,0, 4};   // ignored in FLUSH
        tbl[23] = '{0,0,0,0,0,0,0, 0, 0,0,0, 4};
        tbl[24] = '{0,1,0,1,0,1,1, 0, 0,1,1, 4};   // cmpvalid in IDLE ignored
        tbl[25] = '{1,0,0,0,0,1,1, 0, 0,0,0, 0};   // rst beats taken compare
        tbl[26] = '{0,1,1,0,0,0,0, 1, 1,0,1, 0};
        tbl[27] = '{0,0,0,0,0,0,0, 0, 1,0,1, 1};
        tbl[28] = '{1,1,1,0,0,0,0, 0, 0,0,0, 0};   // rst in FLUSH
        tbl[29] = '{0,1,1,0,0,0,0, 1, 1,0,1, 0};
        tbl[30] = '{0,0,0,0,0,0,0, 0, 1,0,1, 1};
        tbl[31] = '{0,0,0,0,0,0,0, 0, 0,0,0, 1};
        tbl[32] = '{0,0,0,0,0,1,1, 0, 0,0,0, 1};
        tbl[33] = '{0,1,0,1,1,0,0, 0, 0,1,1, 1};   // bne accepted
        tbl[34] = '{0,0,0,0,0,1,0, 2, 1,0,1, 1};   // single WAITCMP, taken
        tbl[35] = '{0,0,0,0,0,0,0, 0, 1,0,1, 2};
        tbl[36] = '{0,0,0,0,0,0,0, 0, 0,0,0, 2};

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            step(tbl[i].r, tbl[i].a, tbl[i].j, tbl[i].b,
                 tbl[i].n, tbl[i].v, tbl[i].e);
            chk("tbl_code",  0, 32'(code0), 32'(tbl[i].code));
            chk("tbl_flush", 0, 32'(fl0),   32'(tbl[i].fl));
            chk("tbl_stall", 0, 32'(st0),   32'(tbl[i].st));
            chk("tbl_busy",  0, 32'(bz0),   32'(tbl[i].bz));
            chk("tbl_cnt",   0, 32'(cnt0),  32'(tbl[i].cnt));
        end

        // Long compare wait: WAITCMP must hold with no timeout.
        step(0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(0, $urandom % 2, 1, 0, 0, 0, 0);
        chk("wait_hold", 0, 32'(st0), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("wait_exit", 0, 32'(bz0), 32'd0);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 64) == 0, $urandom % 2, ($urandom % 4) == 0,
                 $urandom % 2, $urandom % 2, ($urandom % 3) == 0, $urandom % 2);
        end

        // Saturation: continuous jumps drive dut1 past 16'hFFFF.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 1, 0, 0, 0, 0);
        chk("sat_cnt", 1, 32'(cnt1), 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
